// File: rtl/trig_readout_pkg.sv
// Shared defaults, FSM state encoding and header formatting for the trigger window readout.
// The HDR state exists only when TRIG_HEADER_EN is defined.
package trig_readout_pkg;

  localparam int DATA_W_DEFAULT = 32;
  localparam int ADDR_W_DEFAULT = 8;
  localparam logic [7:0] HDR_MARKER = 8'hA5;

`ifdef TRIG_HEADER_EN
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HDR   = 2'd1,
    ST_FETCH = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;
`endif

  function automatic logic [31:0] header_word(input logic [3:0] len, input logic [15:0] cnt);
    return {HDR_MARKER, 4'h0, len, cnt};
  endfunction

endpackage

// File: rtl/trig_ring_ram.sv
// Simple dual-port ring storage: one write port, one read port with registered output.
module trig_ring_ram #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Output only moves on a read, so it stays stable while the reader holds it.
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/trig_window_readout.sv
// Trigger-window readout: continuously records din into a ring and streams a window of past words per trigger.
// Define TRIG_HEADER_EN to prefix each window with a header word carrying window_len and a trigger count.
module trig_window_readout
  import trig_readout_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] din,
  input  logic              trigger,
  input  logic [ADDR_W-1:0] latency,
  input  logic [3:0]        window_len,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              busy,
  output logic [15:0]       trig_dropped,
  output logic              overrun
);

  state_t            state;
  logic [ADDR_W-1:0] wp;
  logic [ADDR_W-1:0] rd_addr;
  logic [4:0]        remaining;
  logic [DATA_W-1:0] ram_rdata;
  logic              ram_re;
  logic              lost_word;
`ifdef TRIG_HEADER_EN
  logic [DATA_W-1:0] hdr_word;
  logic [15:0]       trig_cnt;
`endif

  assign ram_re = (state == ST_FETCH) && (rd_addr != wp);

  trig_ring_ram #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_ring (
    .clk  (clk),
    .we   (!reset),
    .waddr(wp),
    .wdata(din),
    .re   (ram_re),
    .raddr(rd_addr),
    .rdata(ram_rdata)
  );

  // The writer only ever gains on the reader, so landing on the oldest
  // unpresented word means it has lapped the ring. In HOLD the word at
  // rd_addr is already captured, so the next one is the first at risk.
  always_comb begin
    lost_word = 1'b0;
    case (state)
      ST_FETCH: lost_word = (wp == rd_addr);
      ST_HOLD:  lost_word = (wp == rd_addr + ADDR_W'(1)) && (remaining > 5'd1);
`ifdef TRIG_HEADER_EN
      ST_HDR:   lost_word = (wp == rd_addr);
`endif
      default:  lost_word = 1'b0;
    endcase
  end

  always_comb begin
    dout = '0;
    if (state == ST_HOLD) dout = ram_rdata;
`ifdef TRIG_HEADER_EN
    else if (state == ST_HDR) dout = hdr_word;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      wp           <= '0;
      rd_addr      <= '0;
      remaining    <= '0;
      dout_valid   <= 1'b0;
      busy         <= 1'b0;
      trig_dropped <= '0;
      overrun      <= 1'b0;
`ifdef TRIG_HEADER_EN
      hdr_word     <= '0;
      trig_cnt     <= '0;
`endif
    end else begin
      wp <= wp + ADDR_W'(1);
      if (trigger && (state != ST_IDLE) && (trig_dropped != 16'hFFFF))
        trig_dropped <= trig_dropped + 16'd1;
      if (lost_word) overrun <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (trigger) begin
            rd_addr   <= wp - latency;
            remaining <= {1'b0, window_len} + 5'd1;
            busy      <= 1'b1;
`ifdef TRIG_HEADER_EN
            hdr_word   <= DATA_W'(header_word(window_len, trig_cnt));
            trig_cnt   <= trig_cnt + 16'd1;
            dout_valid <= 1'b1;
            state      <= ST_HDR;
`else
            state      <= ST_FETCH;
`endif
          end
        end
`ifdef TRIG_HEADER_EN
        ST_HDR: begin
          if (dout_ready) begin
            dout_valid <= 1'b0;
            state      <= ST_FETCH;
          end
        end
`endif
        ST_FETCH: begin
          if (ram_re) begin
            dout_valid <= 1'b1;
            state      <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (dout_ready) begin
            dout_valid <= 1'b0;
            rd_addr    <= rd_addr + ADDR_W'(1);
            remaining  <= remaining - 5'd1;
            if (remaining == 5'd1) begin
              busy  <= 1'b0;
              state <= ST_IDLE;
            end else begin
              state <= ST_FETCH;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/trig_window_readout.md
TRIG_WINDOW_READOUT -- requirements
Module: trig_window_readout

Interface
REQ-001 SHALL have parameter DATA_W, default 32: width of one 4-channel hit data word.
REQ-002 SHALL have parameter ADDR_W, default 8: ring buffer depth is 2^ADDR_W words.
REQ-003 SHALL have port clk, input, 1: clock, 40 MHz domain.
REQ-004 SHALL have port reset, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port din, input, DATA_W: hit data word, written to the ring every clk cycle.
REQ-006 SHALL have port trigger, input, 1: single-cycle trigger pulse from the trigger selector.
REQ-007 SHALL have port latency, input, ADDR_W: number of cycles back from the trigger cycle where the window starts.
REQ-008 SHALL have port window_len, input, 4: window words minus one (0 gives 1 word, 15 gives 16 words).
REQ-009 SHALL have ports dout (output, DATA_W), dout_valid (output, 1) and dout_ready (input, 1): readout stream with valid/ready handshake.
REQ-010 SHALL have port busy, output, 1: high while a window is being read out.
REQ-011 SHALL have ports trig_dropped (output, 16: count of rejected triggers) and overrun (output, 1: sticky flag for a lost window word).

Function
REQ-012 SHALL write din at write pointer wp every cycle after reset, then increment wp modulo 2^ADDR_W.
REQ-013 SHALL accept a trigger only in IDLE, capturing rd_addr = (wp - latency) mod 2^ADDR_W and remaining = window_len + 1, where wp is the address written in the trigger cycle.
REQ-014 SHALL count a trigger arriving outside IDLE in trig_dropped, saturating at 0xFFFF, and SHALL NOT otherwise act on it.
REQ-015 SHALL implement the FSM IDLE -> (HDR if enabled) -> FETCH -> HOLD -> FETCH... -> IDLE.
REQ-016 FETCH: SHALL issue a read of rd_addr only when rd_addr != wp, so a not-yet-written word is never read; otherwise it SHALL wait in FETCH.
REQ-017 HOLD: SHALL present the read data on dout with dout_valid=1, hold dout stable until dout_ready, then increment rd_addr (wrapping) and decrement remaining; if remaining reaches 0 the FSM SHALL go to IDLE, else to FETCH.
REQ-018 SHALL have a RAM read latency of 1 cycle, with dout registered; a FETCH-to-HOLD transition therefore takes 1 cycle.
REQ-019 SHALL deassert busy exactly in IDLE; a trigger in the first IDLE cycle after a window SHALL be accepted.
REQ-020 SHALL set overrun when, outside IDLE, the write in a cycle targets rd_addr before that word has been presented; the window SHALL still complete its full word count.
REQ-021 SHALL wrap the ring read and write addresses transparently; latency=0 selects the word written in the trigger cycle.

Reset
REQ-022 On reset SHALL set: FSM=IDLE, wp=0, dout=0, dout_valid=0, busy=0, trig_dropped=0, overrun=0, trig_cnt=0; RAM contents are not cleared.
REQ-023 Reset asserted mid-window SHALL abort the window with no further dout_valid.

Configuration
REQ-024 With macro TRIG_HEADER_EN defined, each accepted trigger SHALL first emit, in HDR, the word {8'hA5, 4'h0, window_len, trig_cnt[15:0]} under the same handshake, with trig_cnt incrementing (wrapping) per accepted trigger.
REQ-025 Without TRIG_HEADER_EN, the HDR state and trig_cnt SHALL be absent and a window SHALL contain only data words.

Structure
REQ-026 Package trig_readout_pkg SHALL hold DATA_W/ADDR_W defaults, the FSM state enum and the header marker constant 8'hA5.
REQ-027 The ring SHALL be a sub-module trig_ring_ram (simple dual-port, 1 write port and 1 registered read port).

Verification
REQ-028 din=cycle count, latency=10, window_len=3, trigger at the cycle writing 100, dout_ready=1 -> dout 90,91,92,93, then busy=0.
REQ-029 latency=0, window_len=7 -> the reader stalls in FETCH on unwritten words; outputs 100..107, none read early.
REQ-030 Second trigger 5 cycles after the first -> trig_dropped=1; a trigger on the first IDLE cycle is accepted.
REQ-031 dout_ready=0 for 300 cycles mid-window -> overrun=1, the window still emits 4 words, and dout is stable while stalled.
REQ-032 With TRIG_HEADER_EN: two windows, window_len=2 -> headers 0xA5020000 then 0xA5020001, each followed by 3 data words; reset mid-window -> dout_valid=0 on the next cycle.
